// File: rtl/silife_pkg.sv
// silife_pkg: shared state encodings, default rule masks and state-width helper
package silife_pkg;
   localparam int ST_DEAD        = 0;
   localparam int ST_ALIVE       = 1;
   localparam int ST_DYING_FIRST = 2;
   localparam logic [8:0] RULE_B3  = 9'b000001000;
   localparam logic [8:0] RULE_S23 = 9'b000001100;
   function automatic int state_width(input int states);
      return (states <= 2) ? 1 : $clog2(states);
   endfunction
endpackage

// File: rtl/silife_neighbor_count.sv
// silife_neighbor_count: 4-bit population count of the eight neighbour flags
module silife_neighbor_count (
   input  logic [7:0] bits,
   output logic [3:0] count
);
   always_comb begin
      count = '0;
      for (int i = 0; i < 8; i++) count = count + 4'(bits[i]);
   end
endmodule

// File: rtl/silife_gen_cell.sv
// silife_gen_cell: rule-programmable Life cell with decay states, history, still detector and scan
module silife_gen_cell
   import silife_pkg::*;
#(
   parameter int STATES        = 2,
   parameter int HISTORY_DEPTH = 5,
   parameter int STILL_W       = 4,
   localparam int SW           = state_width(STATES)
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     enable,
   input  logic                     revive,
   input  logic                     kill,
   input  logic [8:0]               rule_birth,
   input  logic [8:0]               rule_survive,
   input  logic [7:0]               neighbors,
   input  logic                     scan_en,
   input  logic                     scan_in,
   output logic                     scan_out,
   output logic                     out,
   output logic [SW-1:0]            state,
   output logic [HISTORY_DEPTH-1:0] history,
   output logic [STILL_W-1:0]       still
);
   localparam logic [SW-1:0] S_DEAD  = SW'(ST_DEAD);
   localparam logic [SW-1:0] S_ALIVE = SW'(ST_ALIVE);
   localparam logic [SW-1:0] S_DECAY = (STATES == 2) ? S_DEAD : SW'(ST_DYING_FIRST);
   logic [3:0]    count;
   logic [31:0]   cur;
   logic [SW-1:0] step;
   silife_neighbor_count u_count (
      .bits  (neighbors),
      .count (count)
   );
   assign cur = 32'(state);
   // dying states advance regardless of neighbours; the last one and any out-of-range value return to dead
   assign step = (cur == ST_DEAD)   ? (rule_birth[count] ? S_ALIVE : S_DEAD) :
                 (cur == ST_ALIVE)  ? (rule_survive[count] ? S_ALIVE : S_DECAY) :
                 (cur < STATES - 1) ? SW'(cur + 1) : S_DEAD;
   assign out      = (state == S_ALIVE);
   assign scan_out = state[SW-1];
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_DEAD;
         history <= '0;
         still   <= '0;
      end else if (scan_en) begin
         state <= SW'({state, scan_in});
      end else if (kill) begin
         state <= S_DEAD;
         still <= '0;
      end else if (revive) begin
         state <= S_ALIVE;
         still <= '0;
      end else if (enable) begin
         state   <= step;
         history <= HISTORY_DEPTH'({history, out});
         still   <= (step != state) ? '0 : (&still) ? still : still + STILL_W'(1);
      end
   end
endmodule

// File: doc/silife_gen_cell.md
Name: silife_gen_cell

Overview:
- Next-generation Life cell with a programmable birth/survival rule (B/S masks, default B3/S23).
- Optional Generations-style decay states, a configurable-depth history shift register, a still-life detector and a serial scan path for load/readback.
- One instance per grid site in the cell array; neighbour `out` signals are wired by the array.

Parameters:
- STATES, 2: number of cell states, 2..16. 0 = dead, 1 = alive, 2..STATES-1 = dying.
- HISTORY_DEPTH, 5: length of the alive-history shift register, >=1.
- STILL_W, 4: width of the saturating still-generation counter.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- enable  in  1  advance one generation.
- revive  in  1  force alive.
- kill  in  1  force dead.
- rule_birth  in  9  bit k set = dead cell with k live neighbours is born.
- rule_survive  in  9  bit k set = alive cell with k live neighbours survives.
- neighbors  in  8  {nw,n,ne,e,se,s,sw,w} alive flags.
- scan_en  in  1  serial shift mode.
- scan_in  in  1  serial data in.
- scan_out  out  1  serial data out = state[SW-1].
- out  out  1  1 iff state == 1 (alive); dying cells read as 0.
- state  out  SW  raw state, SW = clog2(STATES), minimum 1.
- history  out  HISTORY_DEPTH  past `out` values, bit 0 newest.
- still  out  STILL_W  consecutive enabled generations without state change, saturating.

Behaviour:
- All registers update on posedge clk only.
- reset: state=0, history=0, still=0, so out=0 and scan_out=0 the following cycle.
- Priority per cycle: reset > scan_en > kill > revive > enable > hold.
- Neighbour count: 4-bit popcount, 0..8. Count 8 is represented exactly, with no wrap to 0. Indexes rule masks directly.
- enable step, next state by current state:
  - dead: 1 if rule_birth[count], else 0.
  - alive: 1 if rule_survive[count], else (STATES==2 ? 0 : 2).
  - dying k (2 <= k < STATES-1): k+1, unconditional; neighbours ignored.
  - k == STATES-1: 0.
  - Any value >= STATES (loadable only via scan): 0.
- Latency: one cycle from enable to new state/out.
- history <= {history[HISTORY_DEPTH-2:0], out} on enable steps only. Uses the pre-update out. Depth 1 = just out.
- still: on an enable step, +1 (saturating at all-ones) if next state == current state, else cleared to 0.
- kill: state=0.
- revive: state=1.
- kill and revive both clear still and leave history untouched. kill and revive together: kill wins.
- scan_en: state <= {state[SW-2:0], scan_in} (SW==1: state <= scan_in). History and still hold. enable/kill/revive ignored.
- A chain of cells is loaded by SW*N shift cycles.
- Rule inputs are sampled combinationally each step and may change between generations without glitching state.
- Reset asserted mid-scan or mid-decay: overrides everything. No partial state survives.

Decomposition:
- Shared package silife_pkg:
  - state constants ST_DEAD=0, ST_ALIVE=1, ST_DYING_FIRST=2.
  - default rule constants RULE_B3=9'b000001000, RULE_S23=9'b000001100.
  - function state_width(STATES).
- Sub-module silife_neighbor_count: 8-bit in, 4-bit popcount out, purely combinational. Reused by the array's border logic.

Test Plan:
- STATES=2, B3/S23, state dead, neighbors=8'b00000111, enable 1 cycle -> out=1 next cycle, history[0]=0. Second step with neighbors=8'b00000011 -> out stays 1, history=...01.
- rule_survive=9'b100000000 (S8 only), alive cell, neighbors=8'hFF, enable -> stays alive, still increments 0->1. With neighbors=8'h7F -> dies, still=0. Checks count 8 does not alias to 0.
- STATES=4, alive cell, neighbors=0, enable 4 cycles -> state 1,2,3,0,0 and out 1,0,0,0,0. Dying states ignore neighbors=8'hFF.
- kill+revive+enable in the same cycle -> state=0. revive alone -> state=1, still=0, history unchanged.
- STATES=4 (SW=2), scan_en for 2 cycles with scan_in 1 then 1 -> state=3. scan_out shows prior bits. A subsequent enable -> state=0. Loading 2'b11 into a STATES=3 cell -> next enable gives 0.
- Still saturation, STILL_W=2: dead cell, no neighbours, 5 enables -> still 1,2,3,3,3. Reset asserted at cycle 3 of a scan -> state, history and still all 0 next cycle.
